// File: rtl/bsg_manycore_pkg.sv
// bsg_manycore_pkg: reset sequencer state type and counter-width helper
package bsg_manycore_pkg;

   typedef enum logic [1:0] {eAssert, eRelease, eIdle} bsg_manycore_reset_seq_state_e;

   function automatic int bsg_safe_clog2(input int x);
      return (x <= 1) ? 1 : $clog2(x);
   endfunction

endpackage

// File: rtl/bsg_manycore_reset_pipe.sv
// bsg_manycore_reset_pipe: stages_p-deep per-row reset shift register (clk_i, reset_n_i, data_i in; data_o out), all ones under reset
module bsg_manycore_reset_pipe #(
   parameter int width_p  = 1,
   parameter int stages_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_n_i,
   input  logic [width_p-1:0] data_i,
   output logic [width_p-1:0] data_o
);

   logic [stages_p-1:0][width_p-1:0] r_pipe;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) r_pipe <= '1;
      else begin
         r_pipe[0] <= data_i;
         for (int k = 1; k < stages_p; k++) r_pipe[k] <= r_pipe[k-1];
      end
   end

   assign data_o = r_pipe[stages_p-1];

endmodule

// File: rtl/bsg_manycore_reset_sequencer.sv
// bsg_manycore_reset_sequencer: drain-then-staggered row reset release with soft-reset requests (clk_i, reset_n_i, req_v_i/req_row_mask_i in; req_ready_o, row_in_reset_o, tile_reset_o, done_v_o out)
module bsg_manycore_reset_sequencer
   import bsg_manycore_pkg::*;
#(
   parameter int num_tiles_x_p  = -1,
   parameter int num_tiles_y_p  = -1,
   parameter int reset_depth_p  = 3,
   parameter int drain_cycles_p = 4,
   parameter int stagger_p      = 2
) (
   input  logic                                         clk_i,
   input  logic                                         reset_n_i,
   input  logic                                         req_v_i,
   input  logic [num_tiles_y_p-1:0]                     req_row_mask_i,
   output logic                                         req_ready_o,
   output logic [num_tiles_y_p-1:0]                     row_in_reset_o,
   output logic [num_tiles_y_p-1:0][num_tiles_x_p-1:0]  tile_reset_o,
   output logic                                         done_v_o
);

   localparam int dw_lp = bsg_safe_clog2(drain_cycles_p);
   localparam int sw_lp = bsg_safe_clog2(stagger_p);
   localparam int iw_lp = bsg_safe_clog2(num_tiles_y_p);
   localparam logic [dw_lp-1:0] d_last_lp = dw_lp'(drain_cycles_p - 1);
   localparam logic [sw_lp-1:0] s_last_lp = sw_lp'(stagger_p - 1);
   localparam logic [iw_lp-1:0] i_last_lp = iw_lp'(num_tiles_y_p - 1);

   bsg_manycore_reset_seq_state_e r_state, w_state_n;
   logic [dw_lp-1:0]         r_drain, w_drain_n;
   logic [sw_lp-1:0]         r_stag, w_stag_n;
   logic [iw_lp-1:0]         r_idx, w_idx_n;
   logic [num_tiles_y_p-1:0] r_mask, w_mask_n, r_row_reset, w_row_reset_n, w_tile_row;
   logic                     r_done, w_done_n, w_slot;

   always_comb begin
      w_state_n     = r_state;
      w_drain_n     = r_drain;
      w_stag_n      = r_stag;
      w_idx_n       = r_idx;
      w_mask_n      = r_mask;
      w_row_reset_n = r_row_reset;
      w_done_n      = 1'b0;
      w_slot        = (r_stag == '0);
      case (r_state)
         eAssert: begin
            w_drain_n = r_drain + 1'b1;
            if (r_drain == d_last_lp) begin
               w_state_n = eRelease;
               w_idx_n   = '0;
               w_stag_n  = '0;
            end
         end
         eRelease: begin
            w_stag_n = (r_stag == s_last_lp) ? '0 : r_stag + 1'b1;
            if (r_stag == s_last_lp) w_idx_n = r_idx + 1'b1;
            if (w_slot && r_mask[r_idx]) w_row_reset_n[r_idx] = 1'b0;
            if (w_slot && (r_idx == i_last_lp)) begin
               w_state_n = eIdle;
               w_done_n  = 1'b1;
            end
         end
         default: begin
            if (req_v_i) begin
               w_mask_n      = req_row_mask_i;
               w_row_reset_n = r_row_reset | req_row_mask_i;
               // the accept cycle is the first drain cycle, so the count resumes at 1
               w_drain_n     = dw_lp'(1);
               w_state_n     = (drain_cycles_p == 1) ? eRelease : eAssert;
               w_idx_n       = '0;
               w_stag_n      = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         r_state     <= eAssert;
         r_mask      <= '1;
         r_row_reset <= '1;
         r_drain     <= '0;
         r_stag      <= '0;
         r_idx       <= '0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_mask      <= w_mask_n;
         r_row_reset <= w_row_reset_n;
         r_drain     <= w_drain_n;
         r_stag      <= w_stag_n;
         r_idx       <= w_idx_n;
         r_done      <= w_done_n;
      end
   end

   if (reset_depth_p == 1) begin : g_direct
      assign w_tile_row = r_row_reset;
   end else begin : g_pipe
      bsg_manycore_reset_pipe #(
         .width_p (num_tiles_y_p),
         .stages_p(reset_depth_p - 1)
      ) pipe (
         .clk_i    (clk_i),
         .reset_n_i(reset_n_i),
         .data_i   (r_row_reset),
         .data_o   (w_tile_row)
      );
   end

   for (genvar y = 0; y < num_tiles_y_p; y++) begin : g_row
      assign tile_reset_o[y] = {num_tiles_x_p{w_tile_row[y]}};
   end

   assign req_ready_o    = (r_state == eIdle);
   assign row_in_reset_o = r_row_reset;
   assign done_v_o       = r_done;

endmodule

// File: tb/tb_bsg_manycore_reset_sequencer.sv
// tb_bsg_manycore_reset_sequencer: two configurations driven together and checked against a cycle-schedule model
module tb_bsg_manycore_reset_sequencer;

   localparam int Y = 4;
   localparam int D = 4;

   logic             clk = 1'b0;
   logic             reset_n_i = 1'b0;
   logic             req_v_i = 1'b0;
   logic [Y-1:0]     req_row_mask_i = '0;
   logic             ready_o [2];
   logic             done_o  [2];
   logic [Y-1:0]     row_o   [2];
   logic [Y-1:0][1:0] tile_o [2];

   int checks = 0;
   int errors = 0;
   int e = 0;

   bit           wait_s [2] = '{1'b1, 1'b1};
   bit           in_seq [2] = '{1'b0, 1'b0};
   int           start  [2];
   int           lr     [2] = '{0, 0};
   logic [Y-1:0] mask   [2];
   logic [Y-1:0] exp_row [2];
   logic [Y-1:0] exp_tile [2];
   logic         exp_done [2];
   logic         exp_ready [2];
   logic [Y-1:0] hist [2][0:4095];

   always #5 clk = ~clk;

   bsg_manycore_reset_sequencer #(
      .num_tiles_x_p(2), .num_tiles_y_p(Y), .reset_depth_p(3), .drain_cycles_p(D), .stagger_p(2)
   ) dut0 (
      .clk_i(clk), .reset_n_i(reset_n_i), .req_v_i(req_v_i), .req_row_mask_i(req_row_mask_i),
      .req_ready_o(ready_o[0]), .row_in_reset_o(row_o[0]), .tile_reset_o(tile_o[0]), .done_v_o(done_o[0])
   );

   bsg_manycore_reset_sequencer #(
      .num_tiles_x_p(2), .num_tiles_y_p(Y), .reset_depth_p(1), .drain_cycles_p(D), .stagger_p(1)
   ) dut1 (
      .clk_i(clk), .reset_n_i(reset_n_i), .req_v_i(req_v_i), .req_row_mask_i(req_row_mask_i),
      .req_ready_o(ready_o[1]), .row_in_reset_o(row_o[1]), .tile_reset_o(tile_o[1]), .done_v_o(done_o[1])
   );

   function automatic int p_s(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   function automatic int p_dep(input int k);
      return (k == 0) ? 3 : 1;
   endfunction

   function automatic logic [7:0] rep(input logic [Y-1:0] v);
      logic [7:0] t;
      for (int r = 0; r < Y; r++) t[2*r +: 2] = {2{v[r]}};
      return t;
   endfunction

   // Cycle c = e+1 holds the values produced by edge e; a sequence started at edge s
   // releases row r into visibility at s+D+r*S+1 and completes at s+D+(Y-1)*S+1.
   task automatic model(input int k);
      int c;
      c = e + 1;
      if (!reset_n_i) begin
         exp_row[k] = '1;
         mask[k]    = '1;
         wait_s[k]  = 1'b1;
         in_seq[k]  = 1'b0;
         lr[k]      = c;
      end else if (wait_s[k]) begin
         wait_s[k] = 1'b0;
         in_seq[k] = 1'b1;
         start[k]  = e;
      end else if (!in_seq[k] && req_v_i) begin
         in_seq[k]  = 1'b1;
         start[k]   = e;
         mask[k]    = req_row_mask_i;
         exp_row[k] = exp_row[k] | req_row_mask_i;
      end
      exp_done[k] = 1'b0;
      if (in_seq[k]) begin
         for (int r = 0; r < Y; r++)
            if (mask[k][r] && c == start[k] + D + r * p_s(k) + 1) exp_row[k][r] = 1'b0;
         if (c == start[k] + D + (Y - 1) * p_s(k) + 1) begin
            exp_done[k] = 1'b1;
            in_seq[k]   = 1'b0;
         end
      end
      exp_ready[k] = !in_seq[k] && !wait_s[k];
      hist[k][c] = exp_row[k];
      if (c - (p_dep(k) - 1) < lr[k]) exp_tile[k] = '1;
      else exp_tile[k] = hist[k][c - (p_dep(k) - 1)];
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, e + 1, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      for (int k = 0; k < 2; k++) model(k);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("dut%0d_row", k), 8'(row_o[k]), 8'(exp_row[k]));
         chk($sformatf("dut%0d_tile", k), tile_o[k], rep(exp_tile[k]));
         chk($sformatf("dut%0d_done", k), 8'(done_o[k]), 8'(exp_done[k]));
         chk($sformatf("dut%0d_ready", k), 8'(ready_o[k]), 8'(exp_ready[k]));
      end
      e++;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic request(input logic [Y-1:0] m);
      req_v_i = 1'b1;
      req_row_mask_i = m;
      step();
      req_v_i = 1'b0;
   endtask

   initial begin
      // power-on: reset held five cycles then released
      run(5);
      reset_n_i = 1'b1;
      run(20);
      // soft reset of the middle rows
      request(4'b0110);
      run(20);
      // empty mask still runs the timed sequence
      request(4'b0000);
      run(20);
      // request held through a running sequence is taken once, at the ready cycle
      request(4'b1111);
      run(2);
      req_v_i = 1'b1;
      req_row_mask_i = 4'b1001;
      run(11);
      req_v_i = 1'b0;
      run(25);
      // hard reset in the middle of the release walk
      request(4'b1111);
      run(6);
      reset_n_i = 1'b0;
      step();
      reset_n_i = 1'b1;
      run(20);
      // random traffic with occasional hard resets
      for (int i = 0; i < 400; i++) begin
         req_v_i = ($urandom_range(0, 3) == 0);
         req_row_mask_i = Y'($urandom);
         reset_n_i = ($urandom_range(0, 60) != 0);
         step();
      end
      reset_n_i = 1'b1;
      req_v_i = 1'b0;
      run(20);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
